// File: rtl/mem_interp_pkg.sv
// Shared types for the memory-mode interpreter: mode command encoding,
// FSM states and the bundle of RAM / SER / DESER strobes.
package mem_interp_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'b00,
        MODE_LOAD   = 2'b01,
        MODE_UNLOAD = 2'b10,
        MODE_SWAP   = 2'b11
    } mem_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_GUARD  = 2'b01,
        ST_ACTIVE = 2'b10
    } state_e;

    // Bit order matches {block1ena, block1wea, block2ena, block2wea, seriena, deseriena}
    typedef struct packed {
        logic block1ena;
        logic block1wea;
        logic block2ena;
        logic block2wea;
        logic seriena;
        logic deseriena;
    } mem_ctrl_t;

    localparam mem_ctrl_t CTRL_OFF    = mem_ctrl_t'(6'b000000);
    localparam mem_ctrl_t CTRL_LOAD   = mem_ctrl_t'(6'b110001);
    localparam mem_ctrl_t CTRL_UNLOAD = mem_ctrl_t'(6'b001010);
    localparam mem_ctrl_t CTRL_SWAP   = mem_ctrl_t'(6'b101111);

endpackage

// File: rtl/mem_mode_decoder.sv
// Purely combinational mode -> strobe decoder. A write enable is only ever
// produced together with its block enable, and at most one block is written.
module mem_mode_decoder
    import mem_interp_pkg::*;
(
    input  mem_mode_e mode_i,
    output mem_ctrl_t ctrl_o
);

    // Map each mode onto its strobe pattern
    always_comb begin
        ctrl_o = CTRL_OFF;
        case (mode_i)
            MODE_IDLE:   ctrl_o = CTRL_OFF;
            MODE_LOAD:   ctrl_o = CTRL_LOAD;
            MODE_UNLOAD: ctrl_o = CTRL_UNLOAD;
            MODE_SWAP:   ctrl_o = CTRL_SWAP;
            default:     ctrl_o = CTRL_OFF;
        endcase
    end

endmodule

// File: rtl/mem_interpreter.sv
// Memory-mode interpreter: registers decoded strobes for the selected mode and
// inserts GUARD_CYCLES all-off cycles when jumping between two active modes,
// so a RAM bank never sees the old and the new mode on consecutive cycles.
module mem_interpreter
    import mem_interp_pkg::*;
#(
    parameter int unsigned GUARD_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] memoryena,
    output logic       block1ena,
    output logic       block1wea,
    output logic       block2ena,
    output logic       block2wea,
    output logic       seriena,
    output logic       deseriena
);

    localparam int unsigned CNT_W = (GUARD_CYCLES > 32'd0) ? $clog2(GUARD_CYCLES + 32'd1) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD =
        CNT_W'((GUARD_CYCLES > 32'd0) ? (GUARD_CYCLES - 32'd1) : 32'd0);

    state_e           state_q, state_d;
    mem_mode_e        mode_q,  mode_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    mem_ctrl_t        ctrl_q,  ctrl_d;
    mem_ctrl_t        dec_s;
    mem_mode_e        cmd_s;

    assign cmd_s = mem_mode_e'(memoryena);

    // Decode the mode that will be live next cycle; registered below
    mem_mode_decoder u_decoder (
        .mode_i (mode_d),
        .ctrl_o (dec_s)
    );

    // Next-state, latched-mode, guard-counter and output computation
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_s != MODE_IDLE) begin
                    mode_d  = cmd_s;
                    state_d = ST_ACTIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (cmd_s == MODE_IDLE) begin
                    state_d = ST_IDLE;
                end else if (cmd_s == mode_q) begin
                    state_d = ST_ACTIVE;
                end else if (GUARD_CYCLES == 32'd0) begin
                    // No guard requested: switch straight to the new mode
                    mode_d  = cmd_s;
                    state_d = ST_ACTIVE;
                end else begin
                    state_d = ST_GUARD;
                    cnt_d   = CNT_RELOAD;
                end
            end
            ST_GUARD: begin
                if (cmd_s == MODE_IDLE) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == {CNT_W{1'b0}}) begin
                    // Last guard edge: whatever mode is commanded now wins
                    mode_d  = cmd_s;
                    state_d = ST_ACTIVE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                mode_d  = MODE_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase

        if (state_d == ST_ACTIVE) begin
            ctrl_d = dec_s;
        end else begin
            ctrl_d = CTRL_OFF;
        end
    end

    // State and registered strobes; reset forces everything off at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            ctrl_q  <= CTRL_OFF;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign block1ena = ctrl_q.block1ena;
    assign block1wea = ctrl_q.block1wea;
    assign block2ena = ctrl_q.block2ena;
    assign block2wea = ctrl_q.block2wea;
    assign seriena   = ctrl_q.seriena;
    assign deseriena = ctrl_q.deseriena;

endmodule

// File: tb/tb_mem_interpreter.sv
// Directed bench for mem_interpreter with three guard settings (1, 3, 0).
// Outputs are packed as {block1ena, block1wea, block2ena, block2wea, seriena, deseriena}.
module tb_mem_interpreter;

    localparam logic [5:0] OFF    = 6'b000000;
    localparam logic [5:0] LOAD   = 6'b110001;
    localparam logic [5:0] UNLOAD = 6'b001010;
    localparam logic [5:0] SWAP   = 6'b101111;

    logic       clk;
    logic       reset;
    logic [1:0] m1, m3, m0;
    logic [5:0] o1, o3, o0;
    int         checks;
    int         failures;

    mem_interpreter #(.GUARD_CYCLES(1)) dut_g1 (
        .clk(clk), .reset(reset), .memoryena(m1),
        .block1ena(o1[5]), .block1wea(o1[4]), .block2ena(o1[3]),
        .block2wea(o1[2]), .seriena(o1[1]), .deseriena(o1[0])
    );

    mem_interpreter #(.GUARD_CYCLES(3)) dut_g3 (
        .clk(clk), .reset(reset), .memoryena(m3),
        .block1ena(o3[5]), .block1wea(o3[4]), .block2ena(o3[3]),
        .block2wea(o3[2]), .seriena(o3[1]), .deseriena(o3[0])
    );

    mem_interpreter #(.GUARD_CYCLES(0)) dut_g0 (
        .clk(clk), .reset(reset), .memoryena(m0),
        .block1ena(o0[5]), .block1wea(o0[4]), .block2ena(o0[3]),
        .block2wea(o0[2]), .seriena(o0[1]), .deseriena(o0[0])
    );

    // 10 time-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        m1 = 2'b11; m3 = 2'b11; m0 = 2'b11;

        // Asynchronous reset before any clock edge
        #1 reset = 1'b1;
        #1;
        chk("rst_async_g1", o1, OFF);
        chk("rst_async_g3", o3, OFF);
        chk("rst_async_g0", o0, OFF);
        m1 = 2'b00; m3 = 2'b00; m0 = 2'b00;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("idle_hold", o1, OFF);
        end

        // IDLE -> LOAD -> IDLE
        m1 = 2'b01;
        step(); chk("idle_to_load", o1, LOAD);
        m1 = 2'b00;
        step(); chk("load_to_idle", o1, OFF);

        // Long sequence 01,10,11,00 with one guard cycle
        m1 = 2'b01;
        for (int i = 0; i < 100; i++) begin
            step(); chk("seq_load", o1, LOAD);
        end
        m1 = 2'b10;
        step(); chk("seq_guard_lu", o1, OFF);
        for (int i = 0; i < 99; i++) begin
            step(); chk("seq_unload", o1, UNLOAD);
        end
        m1 = 2'b11;
        step(); chk("seq_guard_us", o1, OFF);
        for (int i = 0; i < 99; i++) begin
            step(); chk("seq_swap", o1, SWAP);
        end
        m1 = 2'b00;
        for (int i = 0; i < 100; i++) begin
            step(); chk("seq_idle", o1, OFF);
        end

        // Three guard cycles, LOAD -> UNLOAD -> LOAD
        m3 = 2'b01;
        step(); chk("g3_load", o3, LOAD);
        m3 = 2'b10;
        for (int i = 0; i < 3; i++) begin
            step(); chk("g3_guard_lu", o3, OFF);
        end
        step(); chk("g3_unload", o3, UNLOAD);
        m3 = 2'b01;
        for (int i = 0; i < 3; i++) begin
            step(); chk("g3_guard_ul", o3, OFF);
        end
        step(); chk("g3_reload", o3, LOAD);

        // Abort a guard with 00 during its second cycle
        m3 = 2'b10;
        step(); chk("g3_abort_g1", o3, OFF);
        step(); chk("g3_abort_g2", o3, OFF);
        m3 = 2'b00;
        for (int i = 0; i < 6; i++) begin
            step(); chk("g3_abort_idle", o3, OFF);
        end

        // No guard: LOAD -> SWAP directly
        m0 = 2'b01;
        step(); chk("g0_load", o0, LOAD);
        m0 = 2'b11;
        step(); chk("g0_swap_direct", o0, SWAP);

        // Reset mid-guard (g3) and while in ACTIVE SWAP (g0)
        m3 = 2'b01;
        step(); chk("g3_pre_load", o3, LOAD);
        m3 = 2'b10;
        step(); chk("g3_pre_guard", o3, OFF);
        step(); chk("g0_pre_swap", o0, SWAP);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_guard", o3, OFF);
        chk("rst_in_swap", o0, OFF);
        m0 = 2'b10;
        step();
        chk("rst_held_g3", o3, OFF);
        chk("rst_held_g0", o0, OFF);
        reset = 1'b0;
        step();
        chk("post_rst_g3_unload", o3, UNLOAD);
        chk("post_rst_g0_unload", o0, UNLOAD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
